// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave bridging a fixed address window onto a single-port synchronous SRAM.
// Optional wait states, two-cycle ERROR response, pipelined back-to-back transfers.
module ahb_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  hclk_i,
  input  logic                  hreset_i,
  input  logic                  hsel_i,
  input  logic [31:0]           haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [31:0]           hwdata_i,
  input  logic                  hready_i,
  output logic [31:0]           hrdata_o,
  output logic                  hreadyout_o,
  output logic                  hresp_o,
  output logic                  sram_cs_o,
  output logic                  sram_we_o,
  output logic [3:0]            sram_be_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [31:0]           sram_wdata_o,
  input  logic [31:0]           sram_rdata_i
);

  typedef enum logic [2:0] {
    IDLE, STALL, RD_REQ, RD_RSP, WR, ERR1, ERR2
  } state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [3:0]              be_q, be_d;
  logic                    err_d;
  logic                    take;
  logic                    unused_htrans;

  assign unused_htrans = htrans_i[0];

  // Accepts are only evaluated in states whose data phase ends this cycle.
  assign take = hsel_i & hready_i & htrans_i[1] &
                ((state_q == IDLE) | (state_q == RD_RSP) |
                 (state_q == WR)   | (state_q == ERR2));

  always_comb begin
    be_d = '0;
    case (hsize_i)
      3'd0:    be_d = 4'b0001 << haddr_i[1:0];
      3'd1:    be_d = 4'b0011 << {haddr_i[1], 1'b0};
      3'd2:    be_d = '1;
      default: be_d = '0;
    endcase
    err_d = (haddr_i[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]) |
            (hsize_i > 3'd2) |
            ((hsize_i == 3'd1) & haddr_i[0]) |
            ((hsize_i == 3'd2) & (haddr_i[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STALL: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = '0;
          state_d = write_q ? WR : RD_REQ;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RD_REQ:  state_d = RD_RSP;
      ERR1:    state_d = ERR2;
      default: begin
        // IDLE, RD_RSP, WR, ERR2: pick up the next address phase directly
        state_d = IDLE;
        if (take) begin
          if (err_d) begin
            state_d = ERR1;
          end else if (WS != 3'd0) begin
            state_d = STALL;
            cnt_d   = WS;
          end else begin
            state_d = hwrite_i ? WR : RD_REQ;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        addr_q  <= haddr_i[ADDR_WIDTH+1:2];
        write_q <= hwrite_i;
        be_q    <= be_d;
      end
    end
  end

  always_comb begin
    hreadyout_o  = ~((state_q == STALL) | (state_q == RD_REQ) | (state_q == ERR1));
    hresp_o      = (state_q == ERR1) | (state_q == ERR2);
    hrdata_o     = (state_q == RD_RSP) ? sram_rdata_i : '0;
    sram_cs_o    = (state_q == RD_REQ) | (state_q == WR);
    sram_we_o    = (state_q == WR);
    sram_be_o    = be_q;
    sram_addr_o  = addr_q;
    sram_wdata_o = (state_q == WR) ? hwdata_i : '0;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 3 wait states), each with an SRAM model,
// checked against a byte-level reference memory and transfer-rule expectations.
module tb_ahb_sram_slave;

  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int          NW   = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          hreset [2];
  logic          hsel   [2];
  logic [31:0]   haddr  [2];
  logic [1:0]    htrans [2];
  logic          hwrite [2];
  logic [2:0]    hsize  [2];
  logic [31:0]   hwdata [2];
  logic [31:0]   hrdata [2];
  logic          hreadyout [2];
  logic          hresp  [2];
  logic          cs     [2];
  logic          we     [2];
  logic [3:0]    be     [2];
  logic [AW-1:0] saddr  [2];
  logic [31:0]   swdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] rd;
    logic [31:0] mem [NW];

    ahb_sram_slave #(
      .ADDR_WIDTH (AW),
      .BASE_ADDR  (BASE),
      .WAIT_STATES(g * 3)
    ) u_dut (
      .hclk_i      (clk),
      .hreset_i    (hreset[g]),
      .hsel_i      (hsel[g]),
      .haddr_i     (haddr[g]),
      .htrans_i    (htrans[g]),
      .hwrite_i    (hwrite[g]),
      .hsize_i     (hsize[g]),
      .hwdata_i    (hwdata[g]),
      .hready_i    (hreadyout[g]),
      .hrdata_o    (hrdata[g]),
      .hreadyout_o (hreadyout[g]),
      .hresp_o     (hresp[g]),
      .sram_cs_o   (cs[g]),
      .sram_we_o   (we[g]),
      .sram_be_o   (be[g]),
      .sram_addr_o (saddr[g]),
      .sram_wdata_o(swdata[g]),
      .sram_rdata_i(rd)
    );

    initial for (int i = 0; i < NW; i++) mem[i] = '0;

    always @(posedge clk) begin
      if (cs[g]) begin
        if (we[g]) begin
          for (int b = 0; b < 4; b++)
            if (be[g][b]) mem[saddr[g]][8*b +: 8] <= swdata[g][8*b +: 8];
        end else begin
          rd <= mem[saddr[g]];
        end
      end
    end
  end

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [2][NW];

  logic [31:0] t_addr  [64];
  logic        t_wr    [64];
  logic [2:0]  t_size  [64];
  logic [31:0] t_wdata [64];
  int          t_low   [64];
  logic [31:0] t_rd    [64];
  logic [3:0]  t_be    [64];
  logic [AW-1:0] t_sa  [64];
  int          n_tx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a / 4) % NW;
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic [2:0] sz);
    int unsigned n;
    if ((a / (4 * NW)) != (BASE / (4 * NW))) return 1'b1;
    if (sz > 2) return 1'b1;
    n = 1 << sz;
    return (a % n) != 0;
  endfunction

  // Bytes covered by the transfer, counted out from the byte offset.
  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] sz);
    logic [3:0] m;
    int unsigned lo, n;
    lo = a % 4;
    n  = 1 << sz;
    for (int b = 0; b < 4; b++) m[b] = (b >= lo) && (b < lo + n);
    return m;
  endfunction

  task automatic add(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                     input logic [31:0] wd);
    t_addr[n_tx] = a; t_wr[n_tx] = wr; t_size[n_tx] = sz; t_wdata[n_tx] = wd;
    t_low[n_tx] = -1; t_rd[n_tx] = 'x; t_be[n_tx] = 'x; t_sa[n_tx] = 'x;
    n_tx++;
  endtask

  task automatic gen_random(input int n);
    int unsigned r, a;
    logic [2:0] sz;
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(9);
      sz = 3'($urandom_range(2));
      a  = BASE + 4 * $urandom_range(15) + $urandom_range(3);
      if (r == 0) begin
        a = ($urandom_range(1) != 0) ? BASE + 32'h1000 + $urandom_range(255) : 32'h3000_0000;
      end else if (r == 1) begin
        sz = 3'(3 + $urandom_range(4));
      end else if (r != 2) begin
        a = a - (a % (1 << sz));
      end
      add(a, 1'($urandom_range(1)), sz, $urandom);
    end
  endtask

  task automatic drive_idle(input int d);
    hsel[d]   = 1'($urandom_range(1));
    htrans[d] = hsel[d] ? 2'($urandom_range(1)) : 2'($urandom_range(3));
    haddr[d]  = $urandom;
    hwrite[d] = 1'($urandom_range(1));
    hsize[d]  = 3'($urandom_range(7));
  endtask

  task automatic run(input int d, input bit gaps);
    int cur, nxt, lowc, strobes, viol, cyc;
    bit issued;
    logic err;
    logic [31:0] ew;
    cur = -1; nxt = 0; lowc = 0; strobes = 0; viol = 0; cyc = 0;
    while ((cur >= 0 || nxt < n_tx) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      issued = (nxt < n_tx) && (!gaps || $urandom_range(3) != 0);
      if (issued) begin
        hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = t_addr[nxt];
        hwrite[d] = t_wr[nxt]; hsize[d] = t_size[nxt];
      end else begin
        drive_idle(d);
      end
      hwdata[d] = (cur >= 0 && t_wr[cur]) ? t_wdata[cur] : $urandom;
      #1;
      if (cs[d] === 1'b1) begin
        if (cur < 0) viol++;
        else begin
          strobes++;
          t_be[cur] = be[d]; t_sa[cur] = saddr[d];
          chk("strobe_addr", saddr[d], widx(t_addr[cur]));
          chk("strobe_we", we[d], t_wr[cur]);
          if (t_wr[cur]) begin
            chk("strobe_be", be[d], exp_be(t_addr[cur], t_size[cur]));
            chk("strobe_wdata", swdata[d], t_wdata[cur]);
          end
        end
      end else if (we[d] !== 1'b0) viol++;
      if (cur < 0) begin
        if (hreadyout[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'h0) viol++;
      end else begin
        err = exp_err(t_addr[cur], t_size[cur]);
        if (hreadyout[d] !== 1'b1) begin
          lowc++;
          chk("wait_resp", hresp[d], err);
          if (hrdata[d] !== 32'h0) viol++;
        end else begin
          t_low[cur] = lowc;
          t_rd[cur]  = hrdata[d];
          chk("wait_cycles", lowc, err ? 1 : d * 3 + (t_wr[cur] ? 0 : 1));
          chk("resp", hresp[d], err);
          chk("strobes", strobes, err ? 0 : 1);
          ew = (!err && !t_wr[cur]) ? ref_mem[d][widx(t_addr[cur])] : 32'h0;
          chk("rdata", hrdata[d], ew);
          if (!err && t_wr[cur]) begin
            for (int b = 0; b < 4; b++)
              if (exp_be(t_addr[cur], t_size[cur]) & (4'b0001 << b))
                ref_mem[d][widx(t_addr[cur])][8*b +: 8] = t_wdata[cur][8*b +: 8];
          end
          lowc = 0; strobes = 0;
        end
      end
      if (hreadyout[d] === 1'b1) begin
        cur = issued ? nxt : -1;
        if (issued) nxt++;
      end
    end
    chk("completed", (cur >= 0 || nxt < n_tx), 0);
    chk("protocol", viol, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NW; i++) ref_mem[d][i] = '0;
      hreset[d] = 1'b1; hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = 2'b00;
      hwrite[d] = 1'b0; hsize[d] = 3'd0; hwdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", hreadyout[d], 1'b1);
      chk("rst_resp", hresp[d], 1'b0);
      chk("rst_rdata", hrdata[d], 32'h0);
      chk("rst_cs", cs[d], 1'b0);
      chk("rst_we", we[d], 1'b0);
      hreset[d] = 1'b0;
    end

    // Zero wait states: directed back-to-back sequence
    n_tx = 0;
    add(BASE + 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF);
    add(BASE + 32'h10, 1'b0, 3'd2, 32'h0);
    add(BASE + 32'h11, 1'b1, 3'd0, 32'h1234_AA56);
    add(BASE + 32'h10, 1'b0, 3'd2, 32'h0);
    add(BASE + 32'h1000, 1'b0, 3'd2, 32'h0);
    add(BASE + 32'h03, 1'b0, 3'd1, 32'h0);
    run(0, 1'b0);
    chk("w_be",     t_be[0], 4'b1111);
    chk("w_addr",   t_sa[0], 4);
    chk("w_low",    t_low[0], 0);
    chk("r_low",    t_low[1], 1);
    chk("r_data",   t_rd[1], 32'hDEAD_BEEF);
    chk("b_be",     t_be[2], 4'b0010);
    chk("b_addr",   t_sa[2], 4);
    chk("rb_data",  t_rd[3], 32'hDEAD_AAEF);
    chk("oow_low",  t_low[4], 1);
    chk("half_low", t_low[5], 1);

    n_tx = 0;
    gen_random(40);
    run(0, 1'b1);

    // Three wait states: write then read back-to-back
    n_tx = 0;
    add(BASE + 32'h40, 1'b1, 3'd2, 32'hCAFE_F00D);
    add(BASE + 32'h40, 1'b0, 3'd2, 32'h0);
    run(1, 1'b0);
    chk("ws_w_low",  t_low[0], 3);
    chk("ws_r_low",  t_low[1], 4);
    chk("ws_r_data", t_rd[1], 32'hCAFE_F00D);

    // Reset while stalling
    @(negedge clk);
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = BASE + 32'h40;
    hwrite[1] = 1'b0; hsize[1] = 3'd2;
    @(negedge clk);
    htrans[1] = 2'b00;
    #1;
    chk("stall_low", hreadyout[1], 1'b0);
    hreset[1] = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_stall_ready", hreadyout[1], 1'b1);
    chk("rst_stall_cs", cs[1], 1'b0);
    chk("rst_stall_resp", hresp[1], 1'b0);
    hreset[1] = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_stall_cs2", cs[1], 1'b0);
    n_tx = 0;
    add(BASE + 32'h40, 1'b0, 3'd2, 32'h0);
    run(1, 1'b0);
    chk("post_rst_data", t_rd[0], 32'hCAFE_F00D);

    n_tx = 0;
    gen_random(40);
    run(1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the SRAM word-address width; the window is 2^(ADDR_WIDTH+2) bytes.
REQ-002 Parameter BASE_ADDR, default 32'h2000_0000, SHALL set the window base; it is aligned to the window size.
REQ-003 Parameter WAIT_STATES, default 0, legal range 0..7, SHALL set the extra stall cycles added to every OKAY data phase.
REQ-004 Ports SHALL be:
  hclk_i  in  1  clock, rising edge.
  hreset_i  in  1  synchronous reset, active high.
  hsel_i  in  1  slave select.
  haddr_i  in  32  address.
  htrans_i  in  2  transfer type.
  hwrite_i  in  1  write = 1.
  hsize_i  in  3  transfer size.
  hwdata_i  in  32  write data, valid in data phase.
  hready_i  in  1  bus HREADY.
  hrdata_o  out  32  read data.
  hreadyout_o  out  1  slave ready.
  hresp_o  out  1  1 = ERROR.
  sram_cs_o  out  1  SRAM access strobe.
  sram_we_o  out  1  SRAM write.
  sram_be_o  out  4  SRAM byte enables.
  sram_addr_o  out  ADDR_WIDTH  SRAM word address.
  sram_wdata_o  out  32  SRAM write data.
  sram_rdata_i  in  32  SRAM read data, valid one cycle after a read strobe.
REQ-005 One clock (hclk_i); reset is synchronous and active-high (hreset_i).

Function
REQ-006 A transfer SHALL be accepted on a rising edge only when hsel_i & hready_i & htrans_i[1]; IDLE/BUSY or unselected cycles SHALL get a zero-wait OKAY.
REQ-007 On accept, the block SHALL register haddr_i[ADDR_WIDTH+1:2], hwrite_i, the byte enables and an error flag.
REQ-008 Byte enables SHALL be: byte = 4'b0001<<haddr[1:0]; half = 4'b0011<<(2*haddr[1]); word = 4'b1111.
REQ-009 The error flag SHALL be set when haddr_i[31:ADDR_WIDTH+2] differs from BASE_ADDR[31:ADDR_WIDTH+2], hsize_i > 2, a halfword has haddr_i[0]=1, or a word has haddr_i[1:0]!=0.
REQ-010 FSM states SHALL be IDLE, STALL, RD_REQ, RD_RSP, WR, ERR1, ERR2.
REQ-011 Next state from an accept:
  error -> ERR1;
  else WAIT_STATES>0 -> STALL;
  else read -> RD_REQ;
  else write -> WR.
REQ-012 STALL SHALL drive hreadyout_o=0 for exactly WAIT_STATES cycles using a 3-bit down-counter, then go to RD_REQ or WR.
REQ-013 RD_REQ: sram_cs_o=1, sram_we_o=0, hreadyout_o=0; next state RD_RSP.
REQ-014 RD_RSP: hrdata_o=sram_rdata_i, hreadyout_o=1, hresp_o=0.
REQ-015 Read data-phase length SHALL be 2+WAIT_STATES cycles.
REQ-016 WR: sram_cs_o=1, sram_we_o=1, sram_be_o=registered enables, sram_wdata_o=hwdata_i, hreadyout_o=1.
REQ-017 Write data-phase length SHALL be 1+WAIT_STATES cycles.
REQ-018 ERR1: hreadyout_o=0, hresp_o=1. ERR2: hreadyout_o=1, hresp_o=1. No SRAM strobe in either state.
REQ-019 In IDLE, RD_RSP, WR and ERR2 a new accept SHALL be evaluated in the same cycle (pipelined back-to-back); with no accept the next state is IDLE.
REQ-020 A write followed by a read to the same word SHALL return the new data, because the write strobe precedes the read strobe.
REQ-021 Outside RD_RSP, hrdata_o SHALL be 32'h0.
REQ-022 Outside RD_REQ and WR, sram_cs_o and sram_we_o SHALL be 0.
REQ-023 hresp_o SHALL be 1 only in ERR1 and ERR2.

Reset
REQ-024 While hreset_i=1 at a clock edge: state=IDLE, counter=0, hreadyout_o=1, hresp_o=0, hrdata_o=0, sram_cs_o=0, sram_we_o=0.
REQ-025 Reset asserted mid-transfer SHALL abandon the transfer with no SRAM strobe in the following cycle.

Verification
REQ-026 Bench SHALL cover, with ADDR_WIDTH=10, BASE_ADDR=0x2000_0000, WAIT_STATES=0:
  word write 0xDEADBEEF to 0x2000_0010, then read 0x2000_0010;
  -> write one cycle with sram_be_o=1111 and sram_addr_o=4;
  -> read returns 0xDEADBEEF after one hreadyout_o=0 cycle.
REQ-027 Bench SHALL cover byte write 0xXXXXAAXX to 0x2000_0011 -> sram_be_o=0010 and sram_addr_o=4.
REQ-028 Bench SHALL cover a read of 0x2000_1000 (out of window) -> ERR1 then ERR2, hresp_o=1 both cycles, sram_cs_o=0 throughout.
REQ-029 Bench SHALL cover a halfword read at 0x2000_0003 -> two-cycle ERROR response.
REQ-030 Bench SHALL cover, with WAIT_STATES=3, back-to-back write then read:
  -> write hreadyout_o low for 3 cycles;
  -> read hreadyout_o low for 4 cycles;
  -> read data equals the written data.
REQ-031 Bench SHALL cover hreset_i asserted during STALL -> next cycle hreadyout_o=1 and sram_cs_o=0, and a subsequent read completes normally.
